mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//   Iterative shift-add multiplier controller: sequences one partial-product add per cycle
//   over N cycles, replacing the single-cycle combinational array for area-critical paths.
//   Valid/ready handshake on both sides; sits between an operand producer and a result consumer.
// PARAMETERS
//   N   8   operand width in bits (N >= 2); product width is 2*N
// PORTS
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous reset, active low
//   in_valid   in   1    operands a/b valid
//   in_ready   out  1    block can accept operands this cycle
//   a          in   N    multiplicand, unsigned
//   b          in   N    multiplier, unsigned
//   out_valid  out  1    product valid, held until accepted
//   out_ready  in   1    consumer accepts product
//   out        out  2*N  product a*b, unsigned
//   busy       out  1    high in CALC state
// BEHAVIOUR
// - Reset (rst_n low at posedge clk): state=IDLE, out=0, out_valid=0, busy=0, count=0,
//   a_reg=0, b_reg=0; reset overrides every other event, including mid-CALC and in DONE
// - FSM states: IDLE, CALC, DONE
//   * IDLE: in_ready=1. On in_valid: latch a_reg=a, b_reg=b, acc=0, count=0; go CALC
//   * CALC: in_ready=0, busy=1. Each cycle: if b_reg[count], acc = acc + (a_reg << count),
//     else acc unchanged; count++. The cycle that processes count==N-1 loads out with the
//     final sum and moves to DONE. in_valid ignored in CALC
//   * DONE: out_valid=1, out stable. in_ready = out_ready
//       out_ready=0 -> hold DONE, out and out_valid unchanged
//       out_ready=1 and in_valid=0 -> IDLE, out_valid=0 (out keeps last value)
//       out_ready=1 and in_valid=1 -> accept new operands same edge, go CALC (back-to-back)
// - Latency: operands accepted at edge E; out_valid rises after edge E+N; out valid from then on
// - Throughput: with out_ready tied high, one product every N+1 cycles
// - Arithmetic: acc/out are 2*N bits, zero-extended shift, no truncation; max value
//   (2^N-1)^2 fits, so no overflow handling
// - count width: $clog2(N) bits; never wraps past N-1 within an operation
// - out only changes on the DONE entry edge or on reset; never glitches while out_valid=1
// - a/b are sampled only on the accept edge; later changes have no effect
// TESTING
// 1. N=8, a=0xFF, b=0xFF, out_ready=1 -> out_valid after 8 cycles, out=0xFE01, in_ready back to 1
// 2. a=0x00, b=0xA5 and a=0x37, b=0x00 -> out=0x0000 both, latency still exactly 8 cycles
// 3. a=0x0C, b=0x0A, out_ready low 5 cycles after out_valid -> out=0x0078 held stable,
//    out_valid held, in_ready=0 until out_ready rises
// 4. Back-to-back: in_valid held high, operand pairs (3,5),(200,100),(1,255) with out_ready=1
//    -> outs 0x000F, 0x4E20, 0x00FF, one every 9 cycles, no bubbles
// 5. rst_n low at CALC cycle 4 of a=0x80, b=0x80 -> next edge state IDLE, out=0,
//    out_valid=0, busy=0; next op a=2, b=3 yields out=6
// 6. in_valid pulsed with a=0x11, b=0x22 during CALC of a=0x10, b=0x10 -> ignored,
//    out=0x0100 only

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add multiplier: one partial product per cycle over N cycles,
// with valid/ready handshakes on the operand and product sides.
module mult_seq_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out,
  output logic             busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCount = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  out_q, out_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*N-1:0]  addend;
  logic [2*N-1:0]  sum;

  // Partial product for the multiplier bit selected by count.
  always_comb begin
    addend = b_q[count_q] ? ({{N{1'b0}}, a_q} << count_q) : '0;
    sum    = acc_q + addend;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    out_d    = out_q;
    count_d  = count_q;
    in_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
      end
      StCalc: begin
        acc_d   = sum;
        count_d = count_q + 1'b1;
        if (count_q == LastCount) begin
          out_d   = sum;
          count_d = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Acceptance from IDLE or back-to-back from DONE.
    if (in_valid && in_ready) begin
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      count_d = '0;
      state_d = StCalc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StCalc);
  assign out       = out_q;

endmodule
